pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central stall/flush sequencer for the five-stage CPU pipeline. It produces the write enables for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), plus the bubble-insert clears for IF/ID and ID/EX. Stalls and flushes are driven by three sources: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-RAM accesses using an ack handshake. It also keeps a stall-cycle performance counter and a sticky RAM-timeout flag.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles without `mem_ack` before the block enters ERROR.
- CNT_W, 32: width of `stall_count`.

Ports:
- clk  in  1  pipeline clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- id_rs1_address  in  5  rs1 of the instruction in ID.
- id_rs2_address  in  5  rs2 of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1 each  the ID instruction reads rs1 / rs2.
- ex_rd_address  in  5  rd of the instruction in EX.
- ex_is_load  in  1  the EX instruction is a load (its write data comes from RAM).
- ex_reg_wren  in  1  the EX instruction writes rd.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  the MEM-stage instruction accesses data RAM.
- mem_ack  in  1  RAM controller completion pulse; may arrive in the same cycle as `mem_req`.
- pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren  out  1 each  stage write enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (all-zero control) into the register on this edge.
- mem_timeout  out  1  sticky error flag.
- stall_count  out  CNT_W  count of cycles with `pc_wren`=0 outside reset; wraps.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Outputs are Mealy: combinational from the current state and the current-cycle inputs.
- hazard = ex_is_load & ex_reg_wren & (ex_rd_address≠0) & ((id_rs1_used & rs1==ex_rd_address) | (id_rs2_used & rs2==ex_rd_address)).
  - Register x0 never produces a hazard.
- "Advance decision" is evaluated in priority order:
  1. hazard: `pc_wren`=0, `if_id_wren`=0, `id_ex_flush`=1, all other wrens=1.
  2. else `ex_branch_taken`: all wrens=1, `if_id_flush`=1, `id_ex_flush`=1.
  3. else: all wrens=1, no flush.
- RUN:
  - If `mem_req` & !`mem_ack`: all wrens=0, flushes=0, go to MEM_WAIT with wait counter cleared to 0.
  - Otherwise apply the advance decision and stay in RUN.
- MEM_WAIT:
  - `mem_ack`=1: apply the advance decision and go to RUN.
  - `mem_ack`=0: all wrens=0, flushes=0, wait counter increments.
    - If wait counter == MEM_TIMEOUT-1, set `mem_timeout` and go to ERROR.
  - A taken branch or hazard seen during the wait is not acted on; it is re-evaluated on the release cycle (EX is frozen, so these inputs stay stable).
- ERROR: all wrens=0, flushes=0 until reset. `stall_count` keeps counting.
- `mem_ack` while `mem_req`=0 in RUN is ignored.

## Timing
- Reset (while `reset`=1): state RUN, wait counter 0, `mem_timeout`=0, `stall_count`=0. All wrens=0 and flushes=0 during reset cycles.
- Zero-latency control: decisions take effect on the same clock edge as the inputs.
- Load-use costs exactly 1 bubble cycle.
- Taken branch costs 2 squashed slots and no extra stall cycle.
- RAM access with ack on cycle k after the request costs k stall cycles; k=0 means no stall.
- The cycle ERROR is entered is the MEM_TIMEOUT-th stall cycle.
- Reset asserted mid-MEM_WAIT: returns to RUN on the next edge and any outstanding ack is dropped.

## Structure
- Package `pipeline_ctrl_pkg`: state enum (RUN, MEM_WAIT, ERROR), default MEM_TIMEOUT, register-address width constant (5).
- Sub-module `load_use_detector`: combinational hazard compare producing `hazard`. The FSM, counters and output decode stay in the top module.

## Test plan
- No hazards, `mem_req`=0, 10 cycles -> all wrens=1 every cycle, flushes=0, `stall_count`=0.
- ex_is_load=1, ex_reg_wren=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> for one cycle `pc_wren`=`if_id_wren`=0, `id_ex_flush`=1. Repeating with ex_rd=0 -> no stall.
- `ex_branch_taken` for 1 cycle -> `if_id_flush`=`id_ex_flush`=1 with all wrens=1; branch plus hazard in the same cycle -> hazard response only.
- `mem_req` held, `mem_ack` 3 cycles later -> 3 cycles of all-wren=0, release cycle all wrens=1, `stall_count`=3; `mem_req` with same-cycle ack -> no stall.
- `mem_req` held, no ack, MEM_TIMEOUT=16 -> after 16 stall cycles `mem_timeout`=1, wrens stay 0; later ack ignored; reset clears to RUN with `mem_timeout`=0.
- Reset asserted during MEM_WAIT -> next cycle state RUN, `stall_count`=0, outputs follow RUN decode.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W          = 5;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard compare: the ID instruction needs a register that the load in EX has not produced yet.
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_address,
    input  logic [REG_ADDR_W-1:0] id_rs2_address,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_address,
    input  logic                  ex_is_load,
    input  logic                  ex_reg_wren,
    output logic                  hazard
);

    logic rd_nonzero;
    logic rs1_match;
    logic rs2_match;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    always_comb begin
        rd_nonzero = (ex_rd_address != '0);
        rs1_match  = id_rs1_used && (id_rs1_address == ex_rd_address);
        rs2_match  = id_rs2_used && (id_rs2_address == ex_rd_address);
        hazard     = ex_is_load && ex_reg_wren && rd_nonzero && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: stage write enables, bubble clears, RAM-wait FSM and stall counter.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_address,
    input  logic [REG_ADDR_W-1:0] id_rs2_address,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_address,
    input  logic                  ex_is_load,
    input  logic                  ex_reg_wren,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  pc_wren,
    output logic                  if_id_wren,
    output logic                  id_ex_wren,
    output logic                  ex_mem_wren,
    output logic                  mem_wb_wren,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_count
);

    // Wide enough to hold MEM_TIMEOUT-1; never narrower than one bit.
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    ctrl_state_e       state;
    ctrl_state_e       state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              timeout_set;

    logic hazard;
    logic adv_pc_wren;
    logic adv_if_id_wren;
    logic adv_if_id_flush;
    logic adv_id_ex_flush;

    load_use_detector u_load_use_detector (
        .id_rs1_address (id_rs1_address),
        .id_rs2_address (id_rs2_address),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .ex_rd_address  (ex_rd_address),
        .ex_is_load     (ex_is_load),
        .ex_reg_wren    (ex_reg_wren),
        .hazard         (hazard)
    );

    // Advance decision: hazard bubble beats branch squash; EX and later stages always advance.
    always_comb begin
        adv_pc_wren     = 1'b1;
        adv_if_id_wren  = 1'b1;
        adv_if_id_flush = 1'b0;
        adv_id_ex_flush = 1'b0;
        if (hazard) begin
            adv_pc_wren     = 1'b0;
            adv_if_id_wren  = 1'b0;
            adv_id_ex_flush = 1'b1;
        end else if (ex_branch_taken) begin
            adv_if_id_flush = 1'b1;
            adv_id_ex_flush = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state, wait counter and Mealy output decode; everything frozen while stalled or in reset.
    always_comb begin
        state_next  = state;
        wait_next   = wait_cnt;
        timeout_set = 1'b0;
        pc_wren     = 1'b0;
        if_id_wren  = 1'b0;
        id_ex_wren  = 1'b0;
        ex_mem_wren = 1'b0;
        mem_wb_wren = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        case (state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_next = MEM_WAIT;
                    wait_next  = '0;
                end else begin
                    pc_wren     = adv_pc_wren;
                    if_id_wren  = adv_if_id_wren;
                    id_ex_wren  = 1'b1;
                    ex_mem_wren = 1'b1;
                    mem_wb_wren = 1'b1;
                    if_id_flush = adv_if_id_flush;
                    id_ex_flush = adv_id_ex_flush;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_next  = RUN;
                    pc_wren     = adv_pc_wren;
                    if_id_wren  = adv_if_id_wren;
                    id_ex_wren  = 1'b1;
                    ex_mem_wren = 1'b1;
                    mem_wb_wren = 1'b1;
                    if_id_flush = adv_if_id_flush;
                    id_ex_flush = adv_id_ex_flush;
                end else begin
                    // The request cycle in RUN is stall 1, so reaching MEM_TIMEOUT-1 here is stall MEM_TIMEOUT.
                    wait_next = wait_cnt + WAIT_W'(1);
                    if (wait_next == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        timeout_set = 1'b1;
                        state_next  = ERROR;
                    end
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (reset) begin
            pc_wren     = 1'b0;
            if_id_wren  = 1'b0;
            id_ex_wren  = 1'b0;
            ex_mem_wren = 1'b0;
            mem_wb_wren = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
        end
    end

    // RAM wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            wait_cnt <= wait_next;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Stall performance counter: every non-reset cycle in which the PC is held; wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!pc_wren) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller.
module tb_pipeline_stall_controller;

    localparam int unsigned CNT_W = 32;

    // Control vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    localparam logic [6:0] C_RUN   = 7'b11111_00;
    localparam logic [6:0] C_HAZ   = 7'b00111_01;
    localparam logic [6:0] C_BR    = 7'b11111_11;
    localparam logic [6:0] C_STALL = 7'b00000_00;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs1_address;
    logic [4:0]       id_rs2_address;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_rd_address;
    logic             ex_is_load;
    logic             ex_reg_wren;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             pc_wren;
    logic             if_id_wren;
    logic             id_ex_wren;
    logic             ex_mem_wren;
    logic             mem_wb_wren;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [6:0]       ctl;

    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_sc;

    pipeline_stall_controller #(
        .MEM_TIMEOUT (16),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1_address  (id_rs1_address),
        .id_rs2_address  (id_rs2_address),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd_address   (ex_rd_address),
        .ex_is_load      (ex_is_load),
        .ex_reg_wren     (ex_reg_wren),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_wren         (pc_wren),
        .if_id_wren      (if_id_wren),
        .id_ex_wren      (id_ex_wren),
        .ex_mem_wren     (ex_mem_wren),
        .mem_wb_wren     (mem_wb_wren),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count)
    );

    assign ctl = {pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren, if_id_flush, id_ex_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1_address  = 5'd0;
        id_rs2_address  = 5'd0;
        id_rs1_used     = 1'b0;
        id_rs2_used     = 1'b0;
        ex_rd_address   = 5'd0;
        ex_is_load      = 1'b0;
        ex_reg_wren     = 1'b0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ack         = 1'b0;
    endtask

    task automatic load_hazard(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2);
        ex_is_load     = 1'b1;
        ex_reg_wren    = 1'b1;
        ex_rd_address  = rd;
        id_rs1_address = rs1;
        id_rs1_used    = u1;
        id_rs2_address = rs2;
        id_rs2_used    = u2;
    endtask

    // One clock: inputs already applied after negedge; check Mealy outputs, clock, check counter.
    task automatic cyc(input string tag, input logic [6:0] exp);
        #2;
        check(tag, 64'(ctl), 64'(exp));
        if (reset) exp_sc = '0;
        else if (!exp[6]) exp_sc = exp_sc + 32'd1;
        @(posedge clk);
        #1;
        check({tag, "/cnt"}, 64'(stall_count), 64'(exp_sc));
        @(negedge clk);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        exp_sc = '0;
        idle();
        reset = 1'b1;
        @(negedge clk);

        // Reset: everything held off, state cleared.
        cyc("rst0", C_STALL);
        cyc("rst1", C_STALL);
        check("rst_timeout", 64'(mem_timeout), 64'd0);

        // Free running, no hazards.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cyc("idle", C_RUN);
        check("idle_cnt", 64'(stall_count), 64'd0);

        // Load-use via rs2, then the pipeline moves on.
        load_hazard(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
        cyc("lu_rs2", C_HAZ);
        idle();
        cyc("lu_after", C_RUN);
        // Load-use via rs1.
        load_hazard(5'd12, 5'd12, 1'b1, 5'd3, 1'b0);
        cyc("lu_rs1", C_HAZ);
        // x0 destination never hazards.
        load_hazard(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        cyc("lu_x0", C_RUN);
        // Matching register but not read.
        load_hazard(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        cyc("lu_unused", C_RUN);
        // Not a register-writing load.
        load_hazard(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        ex_reg_wren = 1'b0;
        cyc("lu_nowren", C_RUN);
        // Non-load producer.
        load_hazard(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        ex_is_load = 1'b0;
        cyc("lu_noload", C_RUN);

        // Taken branch alone, then with a hazard.
        idle();
        ex_branch_taken = 1'b1;
        cyc("br", C_BR);
        load_hazard(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        cyc("br_haz", C_HAZ);
        idle();
        cyc("br_after", C_RUN);

        // RAM access acked three cycles after the request.
        mem_req = 1'b1;
        cyc("mw0", C_STALL);
        cyc("mw1", C_STALL);
        cyc("mw2", C_STALL);
        mem_ack = 1'b1;
        cyc("mw_rel", C_RUN);
        // Same-cycle ack costs nothing.
        cyc("mw_zero", C_RUN);
        idle();
        cyc("mw_idle", C_RUN);

        // Branch seen during the wait is acted on only at release.
        mem_req         = 1'b1;
        ex_branch_taken = 1'b1;
        cyc("mwb_wait", C_STALL);
        mem_ack = 1'b1;
        cyc("mwb_rel", C_BR);
        // Stray ack in RUN is ignored.
        idle();
        mem_ack = 1'b1;
        cyc("stray_ack", C_RUN);
        idle();
        cyc("stray_after", C_RUN);

        // No ack: timeout after the 16th stall cycle, then locked.
        mem_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc("to_wait", C_STALL);
            check("to_flag", 64'(mem_timeout), (i == 16) ? 64'd1 : 64'd0);
        end
        mem_ack = 1'b1;
        cyc("err_ack", C_STALL);
        idle();
        cyc("err_idle", C_STALL);
        check("err_flag", 64'(mem_timeout), 64'd1);
        reset = 1'b1;
        cyc("err_rst", C_STALL);
        reset = 1'b0;
        check("err_rst_flag", 64'(mem_timeout), 64'd0);
        cyc("err_run", C_RUN);

        // Reset in the middle of a RAM wait returns to RUN and drops the access.
        mem_req = 1'b1;
        cyc("mr_wait0", C_STALL);
        cyc("mr_wait1", C_STALL);
        reset = 1'b1;
        mem_ack = 1'b1;
        cyc("mr_rst", C_STALL);
        reset = 1'b0;
        idle();
        cyc("mr_run", C_RUN);
        check("mr_flag", 64'(mem_timeout), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
